// File: rtl/heq_lut_builder.sv
// heq_lut_builder: builds the histogram-equalization remap LUT once per frame.
// Each accepted CDF beat is scaled to ((cdf-cdfMin)*(2**DataWidth-1))/(NumPixels-cdfMin)
// with a bit-serial restoring divider, then written to the downstream LUT RAM.
// Optional feature: define HEQ_LUT_ROUND_EN for round-half-up division
// (truncating division when undefined).
module heq_lut_builder #(
    parameter int DataWidth = 8,
    parameter int NumPixels = 640*480,
    parameter int OutWidth  = $clog2(NumPixels+1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [OutWidth-1:0]  i_cdf_min,
    input  logic                 i_cdf_valid,
    input  logic [OutWidth-1:0]  i_cdf,
    output logic                 o_cdf_ready,
    output logic                 o_lut_we,
    output logic [DataWidth-1:0] o_lut_addr,
    output logic [DataWidth-1:0] o_lut_data,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int NW = OutWidth + DataWidth;
    localparam int CW = $clog2(NW+1);
    localparam logic [OutWidth-1:0]  NP       = OutWidth'(NumPixels);
    localparam logic [DataWidth-1:0] LUT_MAX  = '1;
    localparam logic [NW-1:0]        SCALE    = NW'(LUT_MAX);
    localparam logic [CW-1:0]        DIV_LAST = CW'(NW-1);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT_CDF, DIVIDE, WRITE, DONE} state_t;

    state_t                 state_q;
    logic [DataWidth-1:0]   bin_q;
    logic [CW-1:0]          cnt_q;
    logic                   ready_q, we_q, busy_q, done_q;
    logic [DataWidth-1:0]   addr_q, data_q;

    logic [OutWidth-1:0]    cdfmin_q, denom_q, rem_q;
    logic [NW-1:0]          num_q;

    logic [OutWidth-1:0]    cdf_clamp, diff, cdfmin_clamp, round_term, rem_d;
    logic [OutWidth:0]      rem_shift, rem_sub;
    logic [NW-1:0]          num_init, num_d;
    logic                   q_bit;

    // Clamp a quotient to the largest LUT code.
    function automatic logic [DataWidth-1:0] sat_lut(input logic [NW-1:0] q);
        return (q > SCALE) ? LUT_MAX : q[DataWidth-1:0];
    endfunction

    // Beat scaling and one restoring-division step (quotient shifts into num).
    always_comb begin
        cdf_clamp    = (i_cdf > NP) ? NP : i_cdf;
        diff         = (cdf_clamp > cdfmin_q) ? cdf_clamp - cdfmin_q : '0;
        cdfmin_clamp = (cdfmin_q > NP) ? NP : cdfmin_q;
`ifdef HEQ_LUT_ROUND_EN
        round_term   = denom_q >> 1;
`else
        round_term   = '0;
`endif
        num_init  = NW'(diff) * SCALE + NW'(round_term);
        rem_shift = {rem_q, num_q[NW-1]};
        rem_sub   = rem_shift - {1'b0, denom_q};
        q_bit     = (rem_shift >= {1'b0, denom_q});
        rem_d     = q_bit ? rem_sub[OutWidth-1:0] : rem_shift[OutWidth-1:0];
        num_d     = {num_q[NW-2:0], q_bit};
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        busy_q  <= 1'b1;
                        bin_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    ready_q <= 1'b1;
                    state_q <= WAIT_CDF;
                end
                WAIT_CDF: begin
                    if (i_cdf_valid) begin
                        ready_q <= 1'b0;
                        if (denom_q == '0) begin
                            we_q    <= 1'b1;
                            addr_q  <= bin_q;
                            data_q  <= bin_q;
                            state_q <= WRITE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) begin
                        we_q    <= 1'b1;
                        addr_q  <= bin_q;
                        data_q  <= sat_lut(num_d);
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (bin_q == LUT_MAX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        bin_q   <= bin_q + 1'b1;
                        ready_q <= 1'b1;
                        state_q <= WAIT_CDF;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath registers: cdfMin/denominator capture and divider state.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && i_start) begin
            cdfmin_q <= i_cdf_min;
        end
        if (state_q == SETUP) begin
            cdfmin_q <= cdfmin_clamp;
            denom_q  <= NP - cdfmin_clamp;
        end
        if (state_q == WAIT_CDF && i_cdf_valid) begin
            num_q <= num_init;
            rem_q <= '0;
        end
        if (state_q == DIVIDE) begin
            num_q <= num_d;
            rem_q <= rem_d;
        end
    end

    assign o_cdf_ready = ready_q;
    assign o_lut_we    = we_q;
    assign o_lut_addr  = addr_q;
    assign o_lut_data  = data_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_heq_lut_builder.sv
// Directed bench for heq_lut_builder (DataWidth=8, NumPixels=256).
module tb_heq_lut_builder;
    localparam int DW = 8;
    localparam int NP = 256;
    localparam int OW = 9;
    localparam int NW = OW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [OW-1:0] i_cdf_min = '0;
    logic          i_cdf_valid = 1'b0;
    logic [OW-1:0] i_cdf = '0;
    logic          o_cdf_ready, o_lut_we, o_busy, o_done;
    logic [DW-1:0] o_lut_addr, o_lut_data;

    heq_lut_builder #(.DataWidth(DW), .NumPixels(NP)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_cdf_min(i_cdf_min),
        .i_cdf_valid(i_cdf_valid), .i_cdf(i_cdf), .o_cdf_ready(o_cdf_ready),
        .o_lut_we(o_lut_we), .o_lut_addr(o_lut_addr), .o_lut_data(o_lut_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int cdf_tab [256];
    int exp_lut [256];
    int lut     [256];
    int waddr   [256];
    int wtime   [256];
    int atime   [257];
    int wcount, acount, dcount, orphan;
    bit aborted;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records accepts, LUT writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (i_cdf_valid && o_cdf_ready) begin
            if (acount < 257) atime[acount] = cyc;
            acount++;
        end
        if (o_lut_we) begin
            if (wcount >= acount) orphan++;
            if (wcount < 256) begin
                waddr[wcount] = int'(o_lut_addr);
                wtime[wcount] = cyc;
            end
            lut[o_lut_addr] = int'(o_lut_data);
            wcount++;
        end
        if (o_done) dcount++;
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: equalized code from the closed-form expression.
    function automatic int model(input int cdf, input int mn, input int v);
        int c, m, den, diff, r, q;
        c = (cdf > NP) ? NP : cdf;
        m = (mn > NP) ? NP : mn;
        den = NP - m;
        if (den == 0) return v;
        diff = (c > m) ? c - m : 0;
`ifdef HEQ_LUT_ROUND_EN
        r = den / 2;
`else
        r = 0;
`endif
        q = (diff * 255 + r) / den;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic run_build(input int mn, input bit bp, input int abort_at, input bit poke);
        int idx, cycles;
        bit acc, stop;
        wcount = 0; acount = 0; dcount = 0; orphan = 0; aborted = 0;
        for (int v = 0; v < 256; v++) lut[v] = -1;
        @(posedge clk); #1;
        i_cdf_min = OW'(mn);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        idx = 0; cycles = 0; stop = 0;
        i_cdf = OW'(cdf_tab[0]);
        i_cdf_valid = !bp || ($urandom_range(0, 1) == 1);
        while (!stop && dcount == 0 && cycles < 20000) begin
            @(negedge clk);
            acc = i_cdf_valid && o_cdf_ready;
            @(posedge clk); #1;
            cycles++;
            if (acc) idx++;
            i_start = poke && (cycles == 300 || cycles == 301 + 2 * 173);
            if (poke) i_cdf_min = '0;
            if (abort_at >= 0 && idx == abort_at + 1) begin
                stop = 1;
                aborted = 1;
            end
            i_cdf = OW'(cdf_tab[(idx > 255) ? 255 : idx]);
            i_cdf_valid = (idx < 256) && (!bp || ($urandom_range(0, 1) == 1));
        end
        i_cdf_valid = 1'b0;
        i_start = 1'b0;
        if (abort_at < 0) check_val("build_completes", longint'(cycles < 20000), 1);
    endtask

    task automatic check_lut(input string tag);
        int bad, obad;
        bad = 0; obad = 0;
        for (int v = 0; v < 256; v++) begin
            if (lut[v] != exp_lut[v]) bad++;
            if (waddr[v] != v) obad++;
        end
        check_val({tag, "_lut_bad"}, bad, 0);
        check_val({tag, "_order_bad"}, obad, 0);
        check_val({tag, "_writes"}, wcount, 256);
        check_val({tag, "_orphan_writes"}, orphan, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_done_count"}, dcount, 1);
        check_val({tag, "_busy_after"}, longint'(o_busy), 0);
    endtask

    initial begin
        int sp_bad;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_we", longint'(o_lut_we), 0);
        check_val("reset_busy", longint'(o_busy), 0);
        check_val("reset_ready", longint'(o_cdf_ready), 0);
        check_val("reset_done", longint'(o_done), 0);
        check_val("reset_addr", longint'(o_lut_addr), 0);
        check_val("reset_data", longint'(o_lut_data), 0);
        rst = 1'b0;

        // Valid beats while idle must not be consumed.
        wcount = 0; acount = 0;
        i_cdf_valid = 1'b1; i_cdf = 9'd5;
        repeat (5) @(posedge clk);
        #1;
        i_cdf_valid = 1'b0;
        check_val("idle_accepts", acount, 0);
        check_val("idle_writes", wcount, 0);

        // Flat histogram: identity map.
        for (int v = 0; v < 256; v++) begin cdf_tab[v] = v + 1; exp_lut[v] = v; end
        run_build(1, 0, -1, 0);
        check_val("flat_latency", wtime[0] - atime[0], NW + 1);
        check_val("flat_reready", atime[1] - wtime[0], 1);
        check_lut("flat");

        // Two-level image.
        for (int v = 0; v < 256; v++) begin
            cdf_tab[v] = (v < 10) ? 0 : (v < 200) ? 128 : 256;
            exp_lut[v] = (v < 200) ? 0 : 255;
        end
        run_build(128, 0, -1, 0);
        check_lut("twolevel");

        // Rounding with cdfMin = 0.
        for (int v = 0; v < 256; v++) begin cdf_tab[v] = v + 1; exp_lut[v] = model(v + 1, 0, v); end
        run_build(0, 0, -1, 0);
`ifdef HEQ_LUT_ROUND_EN
        check_val("round_lut0", lut[0], 1);
`else
        check_val("round_lut0", lut[0], 0);
`endif
        check_lut("round");

        // Degenerate frame: identity and 2-cycle write spacing.
        for (int v = 0; v < 256; v++) begin cdf_tab[v] = 256; exp_lut[v] = v; end
        run_build(256, 0, -1, 0);
        sp_bad = 0;
        for (int v = 1; v < 256; v++) if (wtime[v] - wtime[v-1] != 2) sp_bad++;
        check_val("degen_spacing_bad", sp_bad, 0);
        check_lut("degen");

        // cdfMin above NumPixels clamps to the degenerate case.
        run_build(300, 0, -1, 0);
        check_lut("clamp");

        // Backpressure: random valid.
        for (int v = 0; v < 256; v++) begin cdf_tab[v] = v + 1; exp_lut[v] = v; end
        run_build(1, 1, -1, 0);
        check_lut("bp");

        // Reset in the middle of bin 100.
        run_build(1, 0, 100, 0);
        check_val("abort_reached", longint'(aborted), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_we", longint'(o_lut_we), 0);
        check_val("abort_busy", longint'(o_busy), 0);
        check_val("abort_ready", longint'(o_cdf_ready), 0);
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_writes", wcount, 100);
        check_val("abort_done", dcount, 0);

        // Re-run with start pulses while busy.
        run_build(1, 0, -1, 1);
        check_lut("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
